syn_fifo_reader: RTL and testbench

Read-side companion to the synchronous FIFO: pops words from a FIFO and presents them on a valid/ready stream, so consumers never handle the FIFO's 1-cycle RAM read latency or empty gating. A 2-entry output buffer sustains 1 word/cycle with arbitrary downstream backpressure. A flush command discards the buffered words and drains the FIFO. It sits between synth sample/command FIFOs and their consumers (voice engines, DAC/I2S serialisers).

---
 rtl/syn_fifo_reader_pkg.sv | 35 +++
 rtl/syn_fifo_reader_obuf.sv | 88 ++++++++
 rtl/syn_fifo_reader.sv | 130 +++++++++++++
 tb/tb_syn_fifo_reader.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/syn_fifo_reader_pkg.sv
// -----------------------------------------------------------------------------
// syn_fifo_reader_pkg
// Shared definitions for the FIFO read-side streamer:
//   state_e     - RUN / FLUSH state encoding of the reader FSM
//   OBUF_DEPTH  - number of words held by the output skid buffer
//   CNT_W       - width of the buffer occupancy count
//   OBUF_LIMIT  - OBUF_DEPTH expressed at the width of an issue level
//   STAT_W      - width of the optional statistics counters
//   issue_level - words the buffer will hold once the in-flight word lands
//                 and the current consumer pop retires
// -----------------------------------------------------------------------------
package syn_fifo_reader_pkg;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_e;

   localparam int OBUF_DEPTH = 2;
   localparam int CNT_W      = $clog2(OBUF_DEPTH + 1);
   localparam int STAT_W     = 16;

   localparam logic [CNT_W:0] OBUF_LIMIT = OBUF_DEPTH[CNT_W:0];

   // One extra bit of headroom: cnt + inflight can momentarily reach 3
   // before the pop is subtracted.
   function automatic logic [CNT_W:0] issue_level(
      input logic [CNT_W-1:0] cnt,
      input logic             inflight,
      input logic             pop
   );
      return {1'b0, cnt} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};
   endfunction

endpackage : syn_fifo_reader_pkg

// File: rtl/syn_fifo_reader_obuf.sv
// -----------------------------------------------------------------------------
// syn_fifo_reader_obuf
// Two-entry output skid buffer. The head entry is the word presented to the
// consumer; the tail entry absorbs the word that lands while the head is
// stalled.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   i_clear        - drop all held words (takes priority over push/pop)
//   i_push         - append i_push_data at the tail
//   i_push_data    - word to append
//   i_pop          - retire the head word (only while o_head_valid)
//   o_cnt          - number of words held (0..2)
//   o_head_data    - head word
//   o_head_valid   - head word is valid
// -----------------------------------------------------------------------------
module syn_fifo_reader_obuf
   import syn_fifo_reader_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clear,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_push_data,
   input  logic              i_pop,
   output logic [CNT_W-1:0]  o_cnt,
   output logic [DATA_W-1:0] o_head_data,
   output logic              o_head_valid
);

   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_head;
   logic [DATA_W-1:0] r_tail;

   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [DATA_W-1:0] w_head_nxt;
   logic [DATA_W-1:0] w_tail_nxt;

   always_comb begin
      w_cnt_nxt  = r_cnt;
      w_head_nxt = r_head;
      w_tail_nxt = r_tail;
      if (i_clear) begin
         w_cnt_nxt = '0;
      end else begin
         case ({i_push, i_pop})
            2'b10: begin
               if (r_cnt == '0) w_head_nxt = i_push_data;
               else             w_tail_nxt = i_push_data;
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
            2'b01: begin
               w_head_nxt = r_tail;
               w_cnt_nxt  = r_cnt - CNT_W'(1);
            end
            2'b11: begin
               // Occupancy unchanged: the head retires and the new word
               // appends behind whatever remains.
               if (r_cnt == CNT_W'(1)) begin
                  w_head_nxt = i_push_data;
               end else begin
                  w_head_nxt = r_tail;
                  w_tail_nxt = i_push_data;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt  <= '0;
         r_head <= '0;
         r_tail <= '0;
      end else begin
         r_cnt  <= w_cnt_nxt;
         r_head <= w_head_nxt;
         r_tail <= w_tail_nxt;
      end
   end

   assign o_cnt        = r_cnt;
   assign o_head_data  = r_head;
   assign o_head_valid = (r_cnt != '0);

endmodule : syn_fifo_reader_obuf

// File: rtl/syn_fifo_reader.sv
// -----------------------------------------------------------------------------
// syn_fifo_reader
// Pops words from a synchronous FIFO (1-cycle read latency) and presents them
// on a valid/ready stream at up to one word per cycle. A flush pulse discards
// the buffered words and drains the FIFO until it is empty with nothing in
// flight.
// Optional build macro: SYN_FIFO_READER_STATS_EN adds transfer/stall counters.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   fifo_rd      - pop strobe to the FIFO (never asserted while fifo_empty)
//   fifo_data    - FIFO read data, valid the cycle after fifo_rd
//   fifo_empty   - FIFO empty flag
//   out_data     - stream data
//   out_valid    - stream data valid
//   out_ready    - consumer ready; transfer = out_valid && out_ready
//   flush        - single-cycle request to discard and drain
//   word_cnt     - (STATS_EN) stream transfers, wraps at 16 bits
//   stall_cnt    - (STATS_EN) cycles with out_valid && !out_ready
//   flush_busy   - drain in progress
// -----------------------------------------------------------------------------
module syn_fifo_reader
   import syn_fifo_reader_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   output logic              fifo_rd,
   input  logic [DATA_W-1:0] fifo_data,
   input  logic              fifo_empty,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   input  logic              flush,
`ifdef SYN_FIFO_READER_STATS_EN
   output logic [STAT_W-1:0] word_cnt,
   output logic [STAT_W-1:0] stall_cnt,
`endif
   output logic              flush_busy
);

   state_e           r_state;
   state_e           w_state_nxt;
   logic             r_inflight;

   logic             w_pop;
   logic             w_push;
   logic             w_clear;
   logic [CNT_W-1:0] w_cnt;
   logic [CNT_W:0]   w_level;

   assign w_pop   = out_valid && out_ready;
   assign w_level = issue_level(w_cnt, r_inflight, w_pop);

   // The word requested last cycle is on fifo_data now.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_RUN;
         r_inflight <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_inflight <= fifo_rd;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      fifo_rd     = 1'b0;
      w_push      = 1'b0;
      w_clear     = 1'b0;
      case (r_state)
         ST_RUN: begin
            // Issue only if the word will still fit after the landing word
            // and this cycle's pop are accounted for.
            fifo_rd = !fifo_empty && (w_level < OBUF_LIMIT);
            w_push  = r_inflight;
            if (flush) begin
               // A word landing this cycle is discarded with the buffer.
               w_clear     = 1'b1;
               w_push      = 1'b0;
               w_state_nxt = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            // Drain at full rate; landing words are dropped (no push).
            fifo_rd = !fifo_empty;
            if (fifo_empty && !r_inflight) w_state_nxt = ST_RUN;
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   syn_fifo_reader_obuf #(
      .DATA_W (DATA_W)
   ) u_obuf (
      .clk          (clk),
      .rst          (rst),
      .i_clear      (w_clear),
      .i_push       (w_push),
      .i_push_data  (fifo_data),
      .i_pop        (w_pop),
      .o_cnt        (w_cnt),
      .o_head_data  (out_data),
      .o_head_valid (out_valid)
   );

   assign flush_busy = (r_state == ST_FLUSH);

`ifdef SYN_FIFO_READER_STATS_EN
   logic [STAT_W-1:0] r_word_cnt;
   logic [STAT_W-1:0] r_stall_cnt;

   // Free-running wrap; flush leaves the counters untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_word_cnt  <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_pop)                   r_word_cnt  <= r_word_cnt + STAT_W'(1);
         if (out_valid && !out_ready) r_stall_cnt <= r_stall_cnt + STAT_W'(1);
      end
   end

   assign word_cnt  = r_word_cnt;
   assign stall_cnt = r_stall_cnt;
`else
   // Statistics counters are not built.
`endif

endmodule : syn_fifo_reader

// File: tb/tb_syn_fifo_reader.sv
// -----------------------------------------------------------------------------
// tb_syn_fifo_reader
// Drives syn_fifo_reader from a behavioural 8-deep synchronous FIFO and checks
// the stream against a scoreboard of written words. Inputs change 1 time unit
// after the rising edge; the monitor samples on the falling edge.
// -----------------------------------------------------------------------------
module tb_syn_fifo_reader;

   logic       clk = 1'b0;
   logic       rst;
   logic       fifo_rd;
   logic [7:0] fifo_data;
   logic       fifo_empty;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       flush;
   logic       flush_busy;
`ifdef SYN_FIFO_READER_STATS_EN
   logic [15:0] word_cnt;
   logic [15:0] stall_cnt;
`endif

   // Bench-side FIFO
   logic       wr;
   logic [7:0] wdata;
   logic [7:0] mem [8];
   logic [2:0] wp, rp;
   logic [3:0] fc;

   // Scoreboard / bookkeeping
   logic [7:0] exp_q [$];
   int         n_checks = 0;
   int         n_pass   = 0;
   int         n_xfer_total = 0;
   int         n_rd_total   = 0;
   int         n_rd_ep = 0;
   int         n_xf_ep = 0;
   logic [7:0] last_xfer;
   logic       prev_stall, prev_flush;
   logic [7:0] prev_data;
   logic [15:0] m_words, m_stalls;

   always #5 clk = ~clk;

   syn_fifo_reader #(.DATA_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_rd    (fifo_rd),
      .fifo_data  (fifo_data),
      .fifo_empty (fifo_empty),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .flush      (flush),
`ifdef SYN_FIFO_READER_STATS_EN
      .word_cnt   (word_cnt),
      .stall_cnt  (stall_cnt),
`endif
      .flush_busy (flush_busy)
   );

   assign fifo_empty = (fc == 4'd0);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         fc <= 4'd0; wp <= 3'd0; rp <= 3'd0; fifo_data <= 8'd0;
      end else begin
         if (fifo_rd && fc != 4'd0) begin
            fifo_data <= mem[rp];
            rp <= rp + 3'd1;
         end
         if (wr && fc < 4'd8) begin
            mem[wp] <= wdata;
            wp <= wp + 3'd1;
         end
         fc <= fc + ((wr && fc < 4'd8) ? 4'd1 : 4'd0)
                  - ((fifo_rd && fc != 4'd0) ? 4'd1 : 4'd0);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Per-cycle compare process
   always @(negedge clk) begin
      if (rst) begin
         n_rd_ep = 0; n_xf_ep = 0; prev_stall = 1'b0; prev_flush = 1'b0;
         m_words = 16'd0; m_stalls = 16'd0;
      end else begin
         check("rd_while_empty", 32'(fifo_rd && fifo_empty), 32'd0);
         if (flush_busy) begin
            check("valid_in_flush", 32'(out_valid), 32'd0);
            n_rd_ep = 0; n_xf_ep = 0;
         end else begin
            check("held_le_2", (n_rd_ep - n_xf_ep) <= 2 ? 32'd1 : 32'd0, 32'd1);
         end
         if (prev_stall && !prev_flush) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'(prev_data));
         end
`ifdef SYN_FIFO_READER_STATS_EN
         check("word_cnt", 32'(word_cnt), 32'(m_words));
         check("stall_cnt", 32'(stall_cnt), 32'(m_stalls));
`endif
         if (out_valid && out_ready) begin
            check("xfer_expected", exp_q.size() != 0 ? 32'd1 : 32'd0, 32'd1);
            if (exp_q.size() != 0) check("xfer_data", 32'(out_data), 32'(exp_q.pop_front()));
            last_xfer = out_data;
            n_xfer_total++;
            n_xf_ep++;
            m_words = m_words + 16'd1;
         end
         if (out_valid && !out_ready) m_stalls = m_stalls + 16'd1;
         if (fifo_rd) n_rd_total++;
         if (fifo_rd && !flush_busy) n_rd_ep++;
         if (flush && !flush_busy) exp_q.delete();
         prev_stall = out_valid && !out_ready;
         prev_flush = flush && !flush_busy;
         prev_data  = out_data;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic push_word(input logic [7:0] d);
      wr = 1'b1; wdata = d; exp_q.push_back(d);
      tick();
      wr = 1'b0;
   endtask

   task automatic wait_xfer(input string name);
      int x0 = n_xfer_total;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (n_xfer_total > x0) break;
      end
      check(name, 32'(n_xfer_total - x0), 32'd1);
   endtask

   task automatic stream(input int n, input int stalls, input int rnd);
      int rem = n;
      int st = stalls;
      int guard = 0;
      while ((rem > 0 || exp_q.size() > 0 || st > 0) && guard < 4 * n + 200) begin
         if (rnd != 0) out_ready = 1'($urandom_range(0, 1));
         else if (st > 0 && out_valid) begin out_ready = 1'b0; st--; end
         else out_ready = 1'b1;
         if (rem > 0 && fc < 4'd8 && (rnd == 0 || $urandom_range(0, 1) == 1)) begin
            wr = 1'b1; wdata = 8'($urandom); exp_q.push_back(wdata); rem--;
         end else begin
            wr = 1'b0;
         end
         tick();
         guard++;
      end
      wr = 1'b0; out_ready = 1'b1;
      check("stream_drained", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rd0, x0, busy;
      rst = 1'b1; wr = 1'b0; wdata = 8'd0; out_ready = 1'b0; flush = 1'b0;
      repeat (3) tick();
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_busy", 32'(flush_busy), 32'd0);
      check("rst_rd", 32'(fifo_rd), 32'd0);
      rst = 1'b0;
      tick();

      // Latency and back-to-back delivery
      out_ready = 1'b1;
      wr = 1'b1; wdata = 8'h11; exp_q.push_back(8'h11);
      tick();
      wdata = 8'h22; exp_q.push_back(8'h22);
      check("lat_e1_valid", 32'(out_valid), 32'd0);
      tick();
      wdata = 8'h33; exp_q.push_back(8'h33);
      check("lat_e2_valid", 32'(out_valid), 32'd0);
      tick();
      wr = 1'b0;
      check("lat_e3_valid", 32'(out_valid), 32'd1);
      check("word0", 32'(out_data), 32'h11);
      tick();
      check("word1_valid", 32'(out_valid), 32'd1);
      check("word1", 32'(out_data), 32'h22);
      tick();
      check("word2_valid", 32'(out_valid), 32'd1);
      check("word2", 32'(out_data), 32'h33);
      tick();
      check("idle_valid", 32'(out_valid), 32'd0);

      // Backpressure: only two pops, then full-rate drain
      out_ready = 1'b0;
      rd0 = n_rd_total;
      for (int i = 0; i < 8; i++) push_word(8'(i));
      repeat (10) tick();
      check("bp_pops", 32'(n_rd_total - rd0), 32'd2);
      check("bp_fifo_cnt", 32'(fc), 32'd6);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_head", 32'(out_data), 32'h00);
      out_ready = 1'b1;
      x0 = n_xfer_total;
      repeat (8) tick();
      check("bp_rate", 32'(n_xfer_total - x0), 32'd8);
      tick();
      check("bp_empty_valid", 32'(out_valid), 32'd0);

      // Randomised ready and write pattern
      stream(200, 0, 1);

      // Flush with 2 buffered and 3 still in the FIFO
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) push_word(8'hA0 + 8'(i));
      repeat (4) tick();
      check("fl_pre_fc", 32'(fc), 32'd3);
      check("fl_pre_valid", 32'(out_valid), 32'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("fl_valid", 32'(out_valid), 32'd0);
      check("fl_busy", 32'(flush_busy), 32'd1);
      busy = 1;
      for (int i = 0; i < 20 && flush_busy; i++) begin
         tick();
         if (flush_busy) busy++;
      end
      check("fl_busy_cycles", 32'(busy), 32'd5);
      check("fl_fifo_empty", 32'(fc), 32'd0);
      out_ready = 1'b1;
      x0 = n_xfer_total;
      push_word(8'hA5);
      if (n_xfer_total == x0) wait_xfer("fl_post_seen");
      check("fl_post_word", 32'(last_xfer), 32'hA5);
      check("fl_post_count", 32'(n_xfer_total - x0), 32'd1);

      // Asynchronous reset with a word in flight
      push_word(8'h01);
      push_word(8'h02);
      push_word(8'h03);
      rst = 1'b1;
      exp_q.delete();
      #1;
      check("ar_valid", 32'(out_valid), 32'd0);
      check("ar_data", 32'(out_data), 32'd0);
      check("ar_rd", 32'(fifo_rd), 32'd0);
      check("ar_busy", 32'(flush_busy), 32'd0);
      repeat (2) tick();
      rst = 1'b0;
      tick();
      x0 = n_xfer_total;
      push_word(8'h5A);
      wait_xfer("ar_post_seen");
      check("ar_post_word", 32'(last_xfer), 32'h5A);
      repeat (4) tick();
      check("ar_no_stale", 32'(n_xfer_total - x0), 32'd1);

`ifdef SYN_FIFO_READER_STATS_EN
      rst = 1'b1;
      exp_q.delete();
      repeat (2) tick();
      rst = 1'b0;
      tick();
      stream(300, 7, 0);
      check("st_words_300", 32'(word_cnt), 32'd300);
      check("st_stalls_7", 32'(stall_cnt), 32'd7);
      stream(65235, 0, 0);
      check("st_words_max", 32'(word_cnt), 32'd65535);
      stream(1, 0, 0);
      check("st_words_wrap", 32'(word_cnt), 32'd0);
      check("st_stalls_keep", 32'(stall_cnt), 32'd7);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_syn_fifo_reader
